maxpool_engine: RTL and testbench

MAXPOOL_ENGINE -- requirements
Module: maxpool_engine

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/pool_addr_gen.sv | 93 +++++++++
 rtl/maxpool_engine.sv | 108 ++++++++++
 tb/tb_maxpool_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN constants and types: per-layer default dimensions, pooling FSM states, ReLU helper.
// Imported by the pooling engine and its address generator.
package cnn_pkg;

  localparam int L1_CHANNELS = 16;
  localparam int L1_IN_DIM   = 26;
  localparam int L2_CHANNELS = 32;
  localparam int L2_IN_DIM   = 11;
  localparam int L1_IN_AW    = 14;
  localparam int L1_OUT_AW   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } pool_state_t;

  function automatic logic signed [7:0] relu8(input logic signed [7:0] v);
    return v[7] ? 8'sd0 : v;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/output counters (k, c, r, ch) and the source/destination address arithmetic for 2x2 pooling.
// Addresses are combinational from the counters; counters step only on k_inc/out_inc, clear on clr.
module pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int CHANNELS = L1_CHANNELS,
  parameter int IN_DIM   = L1_IN_DIM,
  parameter int IN_AW    = L1_IN_AW,
  parameter int OUT_AW   = L1_OUT_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              k_inc,
  input  logic              out_inc,
  output logic [1:0]        k,
  output logic              last_k,
  output logic              last_out,
  output logic [IN_AW-1:0]  rd_addr,
  output logic [OUT_AW-1:0] wr_addr
);

  localparam int OUT_DIM = IN_DIM / 2;
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OD_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  logic [1:0]      k_q, k_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [OD_W-1:0] r_q, r_d;
  logic [OD_W-1:0] c_q, c_d;
  logic            last_c, last_r, last_ch;

  always_comb begin
    last_c  = (c_q == OD_W'(OUT_DIM - 1));
    last_r  = (r_q == OD_W'(OUT_DIM - 1));
    last_ch = (ch_q == CH_W'(CHANNELS - 1));
    k_d  = k_q;
    c_d  = c_q;
    r_d  = r_q;
    ch_d = ch_q;
    if (clr) begin
      k_d  = '0;
      c_d  = '0;
      r_d  = '0;
      ch_d = '0;
    end else begin
      if (k_inc) k_d = k_q + 2'd1;
      // Column is the fastest index, channel the slowest; wrap everything after the final output.
      if (out_inc) begin
        k_d = '0;
        if (!last_c) begin
          c_d = c_q + 1'b1;
        end else begin
          c_d = '0;
          if (!last_r) begin
            r_d = r_q + 1'b1;
          end else begin
            r_d  = '0;
            ch_d = last_ch ? '0 : ch_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q  <= '0;
      c_q  <= '0;
      r_q  <= '0;
      ch_q <= '0;
    end else begin
      k_q  <= k_d;
      c_q  <= c_d;
      r_q  <= r_d;
      ch_q <= ch_d;
    end
  end

  assign k        = k_q;
  assign last_k   = (k_q == 2'd3);
  assign last_out = last_c && last_r && last_ch;

  // Window row = 2r + k[1], col = 2c + k[0]; odd trailing row/col is never generated.
  assign rd_addr = IN_AW'(ch_q) * IN_AW'(IN_DIM * IN_DIM)
                 + IN_AW'({r_q, k_q[1]}) * IN_AW'(IN_DIM)
                 + IN_AW'({c_q, k_q[0]});

  assign wr_addr = OUT_AW'(ch_q) * OUT_AW'(OUT_DIM * OUT_DIM)
                 + OUT_AW'(r_q) * OUT_AW'(OUT_DIM)
                 + OUT_AW'(c_q);

endmodule

// File: rtl/maxpool_engine.sv
// 2x2/stride-2 int8 max-pool over a CHANNELS x IN_DIM x IN_DIM map; 5 cycles per output, no backpressure.
// Optional clamp of results at zero when MAXPOOL_RELU_EN is defined.
module maxpool_engine
  import cnn_pkg::*;
#(
  parameter int CHANNELS = L1_CHANNELS,
  parameter int IN_DIM   = L1_IN_DIM,
  parameter int IN_AW    = L1_IN_AW,
  parameter int OUT_AW   = L1_OUT_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [IN_AW-1:0]         rd_addr,
  input  logic signed [7:0]        rd_data,
  output logic [OUT_AW-1:0]        wr_addr,
  output logic signed [7:0]        wr_data,
  output logic                     wr_en
);

  pool_state_t       state_q, state_d;
  logic signed [7:0] max_q, max_d;
  logic signed [7:0] result;
  logic [1:0]        k;
  logic              last_k, last_out;
  logic              clr, k_inc, out_inc;
  logic [IN_AW-1:0]  gen_rd_addr;
  logic [OUT_AW-1:0] gen_wr_addr;

  pool_addr_gen #(
    .CHANNELS (CHANNELS),
    .IN_DIM   (IN_DIM),
    .IN_AW    (IN_AW),
    .OUT_AW   (OUT_AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .k_inc    (k_inc),
    .out_inc  (out_inc),
    .k        (k),
    .last_k   (last_k),
    .last_out (last_out),
    .rd_addr  (gen_rd_addr),
    .wr_addr  (gen_wr_addr)
  );

`ifdef MAXPOOL_RELU_EN
  assign result = relu8(max_q);
`else
  assign result = max_q;
`endif

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_en   = 1'b0;
    clr     = 1'b0;
    k_inc   = 1'b0;
    out_inc = 1'b0;
    case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (start) state_d = READ;
      end
      READ: begin
        busy    = 1'b1;
        rd_addr = gen_rd_addr;
        k_inc   = 1'b1;
        // First element seeds the running max so the window result never depends on stale state.
        if ((k == 2'd0) || (rd_data > max_q)) max_d = rd_data;
        if (last_k) state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = gen_wr_addr;
        wr_data = result;
        out_inc = 1'b1;
        state_d = last_out ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        clr     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
    end
  end

endmodule

// File: tb/tb_maxpool_engine.sv
// Bench for maxpool_engine: default-size instance (a) and an 11x11x32 instance (b) against a window-max model.
module tb_maxpool_engine;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic        busy_a, busy_b, done_a, done_b, wr_en_a, wr_en_b;
  logic [13:0] rd_addr_a, rd_addr_b;
  logic [7:0]  rd_data_a, rd_data_b;
  logic [11:0] wr_addr_a, wr_addr_b;
  logic [7:0]  wr_data_a, wr_data_b;

  logic [7:0] mem [0:16383];
  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  maxpool_engine u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .wr_en(wr_en_a)
  );

  maxpool_engine #(.CHANNELS(32), .IN_DIM(11), .IN_AW(14), .OUT_AW(12)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .wr_en(wr_en_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;
  int da_cnt = 0;
  int da_cyc = 0;
  int db_cnt = 0;
  int b_bad  = 0;
  int wa_addr[$], wa_data[$], wa_cyc[$];
  int wb_addr[$], wb_data[$];
  int exp_addr[$], exp_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Writes are recorded with the index of the edge that commits them.
  always @(negedge clk) begin
    if (wr_en_a) begin
      wa_addr.push_back(int'(wr_addr_a));
      wa_data.push_back(int'($signed(wr_data_a)));
      wa_cyc.push_back(cyc + 1);
    end
    if (done_a) begin
      da_cnt <= da_cnt + 1;
      da_cyc <= cyc + 1;
    end
    if (wr_en_b) begin
      wb_addr.push_back(int'(wr_addr_b));
      wb_data.push_back(int'($signed(wr_data_b)));
    end
    if (done_b) db_cnt <= db_cnt + 1;
    if (busy_b && ((((int'(rd_addr_b) % 121) / 11) == 10) || (((int'(rd_addr_b) % 121) % 11) == 10)))
      b_bad <= b_bad + 1;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: for every output in channel/row/col order, max of its 2x2 window.
  task automatic build_exp(input int nch, input int idim);
    int od;
    od = idim / 2;
    exp_addr.delete();
    exp_data.delete();
    for (int ch = 0; ch < nch; ch++)
      for (int r = 0; r < od; r++)
        for (int c = 0; c < od; c++) begin
          int m;
          m = -1000;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              int v;
              v = int'($signed(mem[ch*idim*idim + (2*r+dr)*idim + 2*c + dc]));
              if (v > m) m = v;
            end
`ifdef MAXPOOL_RELU_EN
          if (m < 0) m = 0;
`endif
          exp_addr.push_back(ch*od*od + r*od + c);
          exp_data.push_back(m);
        end
  endtask

  function automatic int stream_mism(input int qa[$], input int qd[$]);
    int bad;
    bad = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (i >= qa.size() || qa[i] != exp_addr[i] || qd[i] != exp_data[i]) bad++;
    return bad;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -999;
  endfunction

  task automatic pulse_start_a(output int sc);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_done_a(input int budget);
    int n;
    n = 0;
    while (!done_a && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int s0, s_dummy, d0, n0, n;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[0]  = 8'd5;   mem[1]  = 8'hFD; mem[26] = 8'd7;  mem[27] = 8'd2;
    mem[2]  = 8'hF8;  mem[3]  = 8'hFE; mem[28] = 8'h9C; mem[29] = 8'h80;

    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_wr_en", wr_en_a, 0);
    chk("rst_rd_addr", rd_addr_a, 0);
    chk("rst_wr_addr", wr_addr_a, 0);
    chk("rst_wr_data", wr_data_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pass 1: random map with two directed windows; extra starts while busy and in DONE.
    build_exp(16, 26);
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
    d0 = da_cnt;
    pulse_start_a(s0);
    repeat (100) @(negedge clk);
    pulse_start_a(s_dummy);
    wait_done_a(20000);
    chk("p1_done_seen", done_a, 1);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("p1_idle_after_done", busy_a, 0);
    chk("p1_done_pulses", da_cnt - d0, 1);
    chk("p1_done_latency", da_cyc - s0, 13521);
    chk("p1_write_count", wa_addr.size(), 2704);
    chk("p1_first_latency", q_at(wa_cyc, 0) - s0, 5);
    chk("p1_first_addr", q_at(wa_addr, 0), 0);
    chk("p1_first_data", q_at(wa_data, 0), 7);
`ifdef MAXPOOL_RELU_EN
    chk("p1_neg_window", q_at(wa_data, 1), 0);
`else
    chk("p1_neg_window", q_at(wa_data, 1), -2);
`endif
    chk("p1_last_addr", q_at(wa_addr, wa_addr.size() - 1), 2703);
    chk("p1_stream_mism", stream_mism(wa_addr, wa_data), 0);

    // Odd-dimension instance: trailing row/col dropped.
    build_exp(32, 11);
    wb_addr.delete(); wb_data.delete();
    d0 = db_cnt;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    n = 0;
    while (!done_b && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("b_done_seen", done_b, 1);
    repeat (3) @(negedge clk);
    chk("b_done_pulses", db_cnt - d0, 1);
    chk("b_write_count", wb_addr.size(), 800);
    chk("b_last_addr", q_at(wb_addr, wb_addr.size() - 1), 799);
    chk("b_row_col_10_reads", b_bad, 0);
    chk("b_stream_mism", stream_mism(wb_addr, wb_data), 0);

    // Pass 2: rd_data = low byte of address.
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i);
    build_exp(16, 26);
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
    pulse_start_a(s0);
    wait_done_a(20000);
    chk("p2_done_seen", done_a, 1);
    repeat (2) @(negedge clk);
    chk("p2_done_latency", da_cyc - s0, 13521);
    chk("p2_write_count", wa_addr.size(), 2704);
    chk("p2_last_addr", q_at(wa_addr, wa_addr.size() - 1), 2703);
    chk("p2_stream_mism", stream_mism(wa_addr, wa_data), 0);

    // Asynchronous reset mid-pass, then a fresh pass from output 0.
    pulse_start_a(s_dummy);
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_wr_en", wr_en_a, 0);
    chk("arst_rd_addr", rd_addr_a, 0);
    chk("arst_wr_addr", wr_addr_a, 0);
    @(negedge clk) rst_n = 1'b1;
    n0 = wa_addr.size();
    pulse_start_a(s0);
    repeat (12) @(negedge clk);
    chk("restart_busy", busy_a, 1);
    chk("restart_first_addr", q_at(wa_addr, n0), 0);
    chk("restart_first_latency", q_at(wa_cyc, n0) - s0, 5);
    chk("restart_first_data", q_at(wa_data, n0), exp_data[0]);
    chk("restart_second_addr", q_at(wa_addr, n0 + 1), 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
